// File: rtl/l1_cache_dm.sv
`default_nettype none
// ============================================================================
// Module   : l1_cache_dm
// Brief    : Direct-mapped, write-back, write-allocate L1 cache. Word-wide
//            CPU port with same-cycle hit response. 256-bit line port
//            toward memory, driven by a writeback/fill state machine.
// Revision : 1.0 - initial release
// ============================================================================
module l1_cache_dm #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int S_TAG  = 32 - 5 - S_INDEX;
  localparam int c_SETS = 1 << S_INDEX;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WB   = 2'd1;
  localparam logic [1:0] c_ST_FILL = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;

  logic             r_valid [c_SETS];
  logic             r_dirty [c_SETS];
  logic [S_TAG-1:0] r_tag   [c_SETS];
  logic [255:0]     r_data  [c_SETS];

  // Only the line address of a miss is kept; byte/word offsets are not needed.
  logic [31:5]      r_miss_addr;

  logic [S_INDEX-1:0] w_idx;
  logic [7:0]         w_word_off;
  logic               w_req;
  logic               w_hit;
  logic               w_wr_hit;
  logic               w_miss;
  logic               w_wb_done;
  logic               w_fill_done;
  logic               w_unused;

  // While a miss is in flight the set is selected by the latched miss address,
  // so a flushed or changed CPU request cannot redirect the transaction.
  assign w_idx       = (r_state == c_ST_IDLE) ? mem_address[4+S_INDEX:5]
                                              : r_miss_addr[4+S_INDEX:5];
  assign w_word_off  = {mem_address[4:2], 5'b0};
  assign w_req       = mem_read | mem_write;
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == mem_address[31:5+S_INDEX]);
  assign w_wr_hit    = (r_state == c_ST_IDLE) && mem_write && w_hit;
  assign w_miss      = (r_state == c_ST_IDLE) && w_req && !w_hit;
  assign w_wb_done   = (r_state == c_ST_WB) && pmem_resp;
  assign w_fill_done = (r_state == c_ST_FILL) && pmem_resp;
  assign w_unused    = &{1'b0, mem_address[1:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: a miss evicts a dirty victim first, then fills
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_miss) begin
          w_next_state = (r_valid[w_idx] && r_dirty[w_idx]) ? c_ST_WB : c_ST_FILL;
        end
      end
      c_ST_WB: begin
        if (pmem_resp) begin
          w_next_state = c_ST_FILL;
        end
      end
      c_ST_FILL: begin
        if (pmem_resp) begin
          w_next_state = c_ST_IDLE;
        end
      end
      default: w_next_state = c_ST_IDLE;
    endcase
  end

  // Output logic: CPU response on hits, line port driven from the current state
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = 32'd0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = 256'd0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_req && w_hit) begin
          mem_resp = 1'b1;
          if (!mem_write) begin
            mem_rdata = r_data[w_idx][w_word_off +: 32];
          end
        end
      end
      c_ST_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[w_idx], w_idx, 5'b0};
        pmem_wdata   = r_data[w_idx];
      end
      c_ST_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {r_miss_addr, 5'b0};
      end
      default: ;
    endcase
  end

  // Per-set status bits and the latched miss address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_SETS; i++) begin
        r_valid[i] <= 1'b0;
        r_dirty[i] <= 1'b0;
      end
      r_miss_addr <= '0;
    end else begin
      if (w_miss) begin
        r_miss_addr <= mem_address[31:5];
      end
      if (w_wr_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
      if (w_wb_done) begin
        r_dirty[w_idx] <= 1'b0;
      end
      if (w_fill_done) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: byte-merge on write hits, whole-line install on fill.
  // Reset forces IDLE with all lines invalid, so neither write can fire under reset.
  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_enable[b]) begin
          r_data[w_idx][32'(w_word_off) + 8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
    if (w_fill_done) begin
      r_data[w_idx] <= pmem_rdata;
      r_tag[w_idx]  <= r_miss_addr[31:5+S_INDEX];
    end
  end

endmodule
`default_nettype wire

// File: doc/l1_cache_dm.md
Name: l1_cache_dm

Overview:
- Direct-mapped, write-back, write-allocate L1 cache sitting directly downstream of a CPU memory port.
- One instance serves the instruction port, one serves the data port.
- CPU side: word-wide request held until acknowledged. Memory side: 256-bit line port toward the arbiter/physical memory.
- Hits complete in the cycle presented; misses run a writeback/fill state machine.

Parameters:
S_INDEX, 3, index bits; sets = 2**S_INDEX
S_TAG, 32-5-S_INDEX, tag bits (derived; not overridden)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears state
mem_read  input  1  CPU read request, held until mem_resp
mem_write  input  1  CPU write request, held until mem_resp
mem_byte_enable  input  4  byte lanes for writes
mem_address  input  32  byte address; [4:2] word, [4+S_INDEX:5] index, [31:5+S_INDEX] tag
mem_wdata  input  32  write data
mem_resp  output  1  request complete this cycle
mem_rdata  output  32  read word, valid when mem_resp
pmem_read  output  1  line fill request
pmem_write  output  1  line writeback request
pmem_address  output  32  line address, [4:0]=0
pmem_wdata  output  256  writeback line
pmem_rdata  input  256  fill line, valid with pmem_resp
pmem_resp  input  1  single-cycle completion of pmem transaction

Behaviour:
- Clock is clk; reset is asynchronous and active-high.
- Storage per set: valid, dirty, tag[S_TAG-1:0], data[255:0]. Arrays are read combinationally and written on the clock edge.
- Reset: all valid/dirty = 0, state = IDLE. mem_resp, pmem_read, pmem_write = 0. pmem_address, pmem_wdata, mem_rdata = 0. Reset mid-transaction abandons it: pmem_* deassert immediately and no array is written.
- hit = valid[idx] & (tag[idx] == addr tag).
- IDLE:
  - No request: all outputs 0.
  - Read hit: mem_resp=1 combinationally in the same cycle. mem_rdata = data[idx] word at mem_address[4:2].
  - Write hit: mem_resp=1 the same cycle. At the edge, merge mem_wdata into the addressed word per mem_byte_enable (bit i -> byte i), and set dirty=1.
  - Miss: latch mem_address into miss_addr at the edge, mem_resp=0. Go to WRITEBACK if valid&dirty, else FILL.
  - mem_read & mem_write together: treated as a write.
- WRITEBACK:
  - pmem_write=1; pmem_address = {tag[idx], idx, 5'b0} using miss_addr index; pmem_wdata = data[idx].
  - Hold until pmem_resp. On pmem_resp: dirty[idx]=0, go to FILL.
- FILL:
  - pmem_read=1; pmem_address = {miss_addr[31:5], 5'b0}.
  - On pmem_resp: data=pmem_rdata, tag set, valid=1, dirty=0; go to IDLE.
- After a fill, the request hits on the next IDLE cycle. Total miss-to-resp = pmem latency(s) + 1 cycle. mem_resp is never asserted in WRITEBACK/FILL.
- Request dropped or address changed during WRITEBACK/FILL (pipeline flush): the transaction completes for miss_addr, the line is installed, and it returns to IDLE. The new request is then evaluated normally.
- pmem_read and pmem_write are never both 1. The pmem address and data are stable while waiting for pmem_resp.
- Write-allocate: a write miss fills, then completes as a write hit.
- Byte enable 4'b0000 on write: resp given, data unchanged, dirty still set.

Test Plan:
- Reset, then read 0x0000_0040 -> FILL with pmem_address=0x40 and pmem_read=1. Return line word2=0xDEADBEEF with pmem_resp. Next cycle: mem_resp=1, mem_rdata for 0x48 = 0xDEADBEEF.
- Write hit 0x44, byte_enable=4'b0011, wdata=0x1234_5678 over 0xAAAA_AAAA -> same-cycle mem_resp. Subsequent read returns 0xAAAA_5678, dirty=1.
- Dirty conflict: read 0x0000_0140 (S_INDEX=3, same index as 0x40) -> pmem_write first, address 0x40, wdata containing 0xAAAA_5678. Then pmem_read at 0x140. Then mem_resp.
- Flush mid-fill: read 0x200, drop mem_read two cycles later -> pmem_read held to pmem_resp, no mem_resp. A later read 0x200 hits in 0 cycles with no pmem activity.
- Assert reset during FILL -> pmem_read falls without a clock edge. After release, re-read of the same address misses again.
- Back-to-back hits on 8 sets, one read per cycle -> mem_resp=1 every cycle, pmem idle.
